// File: rtl/sample_filter_pkg.sv
// Shared types and helpers for the sample filter pipeline: FSM states,
// default sizing and the packed-variable slot extractor.
package sample_filter_pkg;

    localparam int DEF_NUM_VARS = 50;
    localparam int DEF_VAR_W    = 8;
    localparam int DEF_NUM_CONS = 50;
    localparam int DEF_TAG_W    = 8;
    localparam int DEF_CNT_W    = 32;

    // Upper bounds for the slot extractor; instances must stay within them.
    localparam int MAX_DATA_W = 4096;
    localparam int MAX_VAR_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic logic [MAX_VAR_W-1:0] var_slot(
        input logic [MAX_DATA_W-1:0] data,
        input int unsigned           k,
        input int unsigned           var_w
    );
        logic [MAX_VAR_W-1:0] mask;
        mask = ~({MAX_VAR_W{1'b1}} << var_w);
        return MAX_VAR_W'(data >> (k * var_w)) & mask;
    endfunction

endpackage

// File: rtl/sample_filter_if.sv
// Candidate/result stream bundle between the sampler source, the filter
// pipeline and the downstream consumer.
interface sample_filter_if
    import sample_filter_pkg::*;
#(
    parameter int NUM_VARS = DEF_NUM_VARS,
    parameter int VAR_W    = DEF_VAR_W,
    parameter int NUM_CONS = DEF_NUM_CONS,
    parameter int TAG_W    = DEF_TAG_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_VARS*VAR_W-1:0] in_data;
    logic [TAG_W-1:0]          in_tag;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_VARS*VAR_W-1:0] out_data;
    logic [TAG_W-1:0]          out_tag;
    logic                      out_sat;
    logic [NUM_CONS-1:0]       out_fail_mask;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_sat, out_fail_mask
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_sat, out_fail_mask
    );

endinterface

// File: rtl/constraint_eval.sv
// Combinational constraint set: constraint k is true when variable
// (k mod NUM_VARS) is nonzero.
module constraint_eval
    import sample_filter_pkg::*;
#(
    parameter int NUM_VARS = DEF_NUM_VARS,
    parameter int VAR_W    = DEF_VAR_W,
    parameter int NUM_CONS = DEF_NUM_CONS
) (
    input  logic [NUM_VARS*VAR_W-1:0] vars,
    output logic [NUM_CONS-1:0]       cons_vec
);

    logic [MAX_DATA_W-1:0] vars_ext;

    assign vars_ext = MAX_DATA_W'(vars);

    for (genvar k = 0; k < NUM_CONS; k++) begin : g_cons
        assign cons_vec[k] = |var_slot(vars_ext, k % NUM_VARS, VAR_W);
    end

endmodule

// File: rtl/sample_filter_pipe.sv
// Two-stage streaming constraint filter with run control, a satisfying-sample
// target and saturating statistics counters.
module sample_filter_pipe
    import sample_filter_pkg::*;
#(
    parameter int NUM_VARS = DEF_NUM_VARS,
    parameter int VAR_W    = DEF_VAR_W,
    parameter int NUM_CONS = DEF_NUM_CONS,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             emit_all,
    sample_filter_if.slave   bus,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] sat_cnt,
    output logic             busy,
    output logic             done
);

    localparam int DATA_W = NUM_VARS * VAR_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic                emit_all_q, emit_all_d;
    logic [CNT_W-1:0]    checked_q, checked_d;
    logic [CNT_W-1:0]    sat_q, sat_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   s2_data_q, s2_data_d;
    logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
    logic                s2_sat_q, s2_sat_d;
    logic [NUM_CONS-1:0] s2_fail_q, s2_fail_d;

    logic [NUM_CONS-1:0] cons_vec;
    logic                stall;
    logic                in_ready;
    logic                accept;
    logic                sat_hs;
    logic                target_hit;

    constraint_eval #(
        .NUM_VARS (NUM_VARS),
        .VAR_W    (VAR_W),
        .NUM_CONS (NUM_CONS)
    ) u_eval (
        .vars     (s1_data_q),
        .cons_vec (cons_vec)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch below can leave one unassigned and infer a latch.
        state_d    = state_q;
        target_d   = target_q;
        emit_all_d = emit_all_q;
        checked_d  = checked_q;
        sat_d      = sat_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_sat_d   = s2_sat_q;
        s2_fail_d  = s2_fail_q;

        stall    = s2_valid_q && !bus.out_ready;
        in_ready = (state_q == RUN) && !stall;
        accept   = bus.in_valid && in_ready;
        sat_hs   = s2_valid_q && bus.out_ready && s2_sat_q;

        if (sat_hs && (sat_q != '1)) sat_d = sat_q + CNT_W'(1);
        // Include this cycle's handshake so the sample entering S2 cannot overshoot.
        target_hit = (target_q != '0) && (sat_d >= target_q);

        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = bus.in_data;
                s1_tag_d  = bus.in_tag;
            end
            s2_valid_d = 1'b0;
            if (s1_valid_q) begin
                if (checked_q != '1) checked_d = checked_q + CNT_W'(1);
                if (!target_hit && (emit_all_q || (&cons_vec))) begin
                    s2_valid_d = 1'b1;
                    s2_data_d  = s1_data_q;
                    s2_tag_d   = s1_tag_q;
                    s2_sat_d   = &cons_vec;
                    s2_fail_d  = ~cons_vec;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    target_d   = target;
                    emit_all_d = emit_all;
                    checked_d  = '0;
                    sat_d      = '0;
                end
            end
            RUN:     if (target_hit) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so every flop samples the pre-edge _d values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            emit_all_q <= 1'b0;
            checked_q  <= '0;
            sat_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_sat_q   <= 1'b0;
            s2_fail_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            emit_all_q <= emit_all_d;
            checked_q  <= checked_d;
            sat_q      <= sat_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_sat_q   <= s2_sat_d;
            s2_fail_q  <= s2_fail_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_data      = s2_data_q;
    assign bus.out_tag       = s2_tag_q;
    assign bus.out_sat       = s2_sat_q;
    assign bus.out_fail_mask = s2_fail_q;
    assign checked_cnt       = checked_q;
    assign sat_cnt           = sat_q;
    assign busy              = (state_q == RUN) || (state_q == DRAIN);
    assign done              = (state_q == DONE);

endmodule

// File: tb/tb_sample_filter_pipe.sv
// Self-checking bench: a transaction-level reference (expected output queue)
// plus directed scenarios and randomized runs.
module tb_sample_filter_pipe;

    localparam int NUM_VARS = 4;
    localparam int VAR_W    = 8;
    localparam int NUM_CONS = 4;
    localparam int TAG_W    = 8;
    localparam int CNT_W    = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] target;
    logic             emit_all;
    logic [CNT_W-1:0] checked_cnt;
    logic [CNT_W-1:0] sat_cnt;
    logic             busy;
    logic             done;

    sample_filter_if #(
        .NUM_VARS (NUM_VARS),
        .VAR_W    (VAR_W),
        .NUM_CONS (NUM_CONS),
        .TAG_W    (TAG_W)
    ) bus ();

    sample_filter_pipe #(
        .NUM_VARS (NUM_VARS),
        .VAR_W    (VAR_W),
        .NUM_CONS (NUM_CONS),
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target      (target),
        .emit_all    (emit_all),
        .bus         (bus),
        .checked_cnt (checked_cnt),
        .sat_cnt     (sat_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic        sat;
        logic [3:0]  fail;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  seen_tag[$];
    logic        seen_sat[$];
    logic [3:0]  seen_fail[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int m_target;
    bit m_emit_all;
    int m_sat_queued;
    int m_accepted;
    int m_sat_hs;
    int m_hs;

    bit          lat_check = 1'b0;
    bit          stop_rand = 1'b0;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [7:0]  prev_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A constraint is false when its variable byte is zero.
    function automatic logic [3:0] model_fail(input logic [31:0] d);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (((d >> (8 * k)) & 32'hFF) == 32'd0);
        return m;
    endfunction

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        for (int k = 0; k < 4; k++)
            d[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        return d;
    endfunction

    always @(posedge clk) cyc++;

    // Reference model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall   = 1'b0;
            m_sat_queued = 0;
            m_accepted   = 0;
            m_sat_hs     = 0;
            m_hs         = 0;
        end else begin
            if (start) begin
                m_target     = int'(target);
                m_emit_all   = emit_all;
                m_sat_queued = 0;
                m_accepted   = 0;
                m_sat_hs     = 0;
                m_hs         = 0;
            end
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold_data", 64'(bus.out_data), 64'(prev_data));
                check("stall_hold_tag", 64'(bus.out_tag), 64'(prev_tag));
            end
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_stalled", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                m_hs++;
                seen_tag.push_back(bus.out_tag);
                seen_sat.push_back(bus.out_sat);
                seen_fail.push_back(bus.out_fail_mask);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag 0x%0h, expected no output", bus.out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                    check("out_sat", 64'(bus.out_sat), 64'(e.sat));
                    check("out_fail_mask", 64'(bus.out_fail_mask), 64'(e.fail));
                    if (lat_check) check("latency", 64'(cyc - e.cyc), 64'd2);
                    if (e.sat) m_sat_hs++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.data = bus.in_data;
                e.tag  = bus.in_tag;
                e.fail = model_fail(bus.in_data);
                e.sat  = (e.fail == 4'd0);
                e.cyc  = cyc;
                m_accepted++;
                if (!(m_target != 0 && m_sat_queued >= m_target) && (m_emit_all || e.sat)) begin
                    exp_q.push_back(e);
                    if (e.sat) m_sat_queued++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_tag   = bus.out_tag;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start(input int t, input bit ea);
        @(posedge clk); #1;
        target   = t;
        emit_all = ea;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && !done && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!done) check("send_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            n++;
            @(negedge clk);
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int base;
        rst          = 1'b1;
        start        = 1'b0;
        target       = '0;
        emit_all     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_tag   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_fail_mask", 64'(bus.out_fail_mask), 64'd0);
        check("rst_checked", 64'(checked_cnt), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Filter, emit_all = 0
        do_start(3, 1'b0);
        @(negedge clk);
        check("start_busy", 64'(busy), 64'd1);
        check("start_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        lat_check = 1'b1;
        base = seen_tag.size();
        send(32'h04030201, 8'h10);
        send(32'h04030200, 8'h11);
        repeat (5) @(negedge clk);
        check("filt_count", 64'(seen_tag.size() - base), 64'd1);
        check("filt_tag", 64'(seen_tag[base]), 64'h10);
        check("filt_sat", 64'(seen_sat[base]), 64'd1);
        check("filt_mask", 64'(seen_fail[base]), 64'd0);
        check("filt_checked", 64'(checked_cnt), 64'd2);
        check("filt_sat_cnt", 64'(sat_cnt), 64'd1);

        // Same stimulus, emit_all = 1
        do_reset();
        do_start(3, 1'b1);
        base = seen_tag.size();
        send(32'h04030201, 8'h10);
        send(32'h04030200, 8'h11);
        repeat (5) @(negedge clk);
        check("all_count", 64'(seen_tag.size() - base), 64'd2);
        check("all_tag1", 64'(seen_tag[base+1]), 64'h11);
        check("all_sat1", 64'(seen_sat[base+1]), 64'd0);
        check("all_mask1", 64'(seen_fail[base+1]), 64'h1);
        check("all_checked", 64'(checked_cnt), 64'd2);
        check("all_sat_cnt", 64'(sat_cnt), 64'd1);

        // Backpressure
        do_reset();
        do_start(0, 1'b0);
        lat_check = 1'b0;
        base = seen_tag.size();
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'h11111111, 8'h20);
                send(32'h22222222, 8'h21);
                send(32'h33333333, 8'h22);
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check("bp_count", 64'(seen_tag.size() - base), 64'd3);
        check("bp_tag0", 64'(seen_tag[base]), 64'h20);
        check("bp_tag1", 64'(seen_tag[base+1]), 64'h21);
        check("bp_tag2", 64'(seen_tag[base+2]), 64'h22);

        // Target stop
        do_reset();
        do_start(2, 1'b0);
        lat_check = 1'b1;
        send(32'h01010101, 8'h30);
        send(32'h02020202, 8'h31);
        send(32'h03030303, 8'h32);
        send(32'h04040404, 8'h33);
        wait_done(50);
        check("tgt_handshakes", 64'(m_hs), 64'd2);
        check("tgt_sat_cnt", 64'(sat_cnt), 64'd2);
        check("tgt_checked", 64'(checked_cnt), 64'd4);
        check("tgt_in_ready", 64'(bus.in_ready), 64'd0);
        check("tgt_busy", 64'(busy), 64'd0);
        check("tgt_queue_empty", 64'(exp_q.size()), 64'd0);
        do_start(5, 1'b0);
        @(negedge clk);
        check("restart_checked", 64'(checked_cnt), 64'd0);
        check("restart_sat_cnt", 64'(sat_cnt), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);

        // Randomized runs
        lat_check = 1'b0;
        for (int run = 0; run < 6; run++) begin
            int t;
            bit ea;
            do_reset();
            t  = $urandom_range(0, 4);
            ea = 1'($urandom_range(0, 1));
            do_start(t, ea);
            stop_rand = 1'b0;
            fork
                while (!stop_rand) begin
                    @(posedge clk); #1;
                    if (!stop_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            join_none
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send(rand_data(), 8'(run * 32 + i));
            end
            stop_rand = 1'b1;
            @(posedge clk); #2;
            bus.out_ready = 1'b1;
            repeat (10) @(negedge clk);
            check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
            check("rnd_checked", 64'(checked_cnt), 64'(m_accepted));
            check("rnd_sat_cnt", 64'(sat_cnt), 64'(m_sat_hs));
            if (t != 0 && m_sat_queued >= t) check("rnd_done", 64'(done), 64'd1);
        end

        // Reset while both stages hold samples
        do_reset();
        do_start(0, 1'b0);
        bus.out_ready = 1'b0;
        send(32'h05050505, 8'h40);
        send(32'h06060606, 8'h41);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_checked", 64'(checked_cnt), 64'd0);
        check("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
